// File: rtl/General1.sv
// Shared definitions for the PWM receive path.
//   pwm_dem_state_t : demodulator FSM states
//   pwm_ticks()     : clock ticks per nominal PWM period (integer division)
package General1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } pwm_dem_state_t;

    function automatic int unsigned pwm_ticks(input int unsigned clock_period_ns,
                                              input int unsigned pwm_period_ns);
        return pwm_period_ns / clock_period_ns;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (output clears to 0)
//   i_d   : asynchronous input
//   o_q   : synchronized output, two clk edges of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pwm_demodulator.sv
// Recovers a Size-bit duty code from a PWM line once per Synch period and
// flags lost Synch and periods carrying more than one pulse.
//   Clock : system clock
//   Reset : asynchronous active-low reset
//   PWM   : asynchronous PWM line
//   Synch : asynchronous period-start strobe
//   Code  : recovered duty code, held between updates
//   Valid : one-cycle pulse when Code/Error update
//   Lost  : Synch missing for two nominal periods
//   Error : last reported period had two or more rising edges
module pwm_demodulator
    import General1::*;
#(
    parameter int unsigned Size           = 4,
    parameter int unsigned ClockPeriod_ns = 20,
    parameter int unsigned PWMPeriod_ns   = 850,
    parameter string       PWMType        = "Back"
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            PWM,
    input  logic            Synch,
    output logic [Size-1:0] Code,
    output logic            Valid,
    output logic            Lost,
    output logic            Error
);

    localparam int unsigned M        = (1 << Size) - 1;
    localparam int unsigned TICKS    = pwm_ticks(ClockPeriod_ns, PWMPeriod_ns);
    localparam int unsigned ACC_W    = $clog2(TICKS + M) + 1;
    localparam int unsigned GAP_MAX  = 2 * TICKS;
    localparam int unsigned GAP_W    = $clog2(GAP_MAX + 1);

    // Elaboration-time parameter sanity
    if (TICKS < M) begin : g_chk_ticks
        $error("pwm_demodulator: PeriodTicks must be >= 2**Size-1");
    end
    if ((PWMType != "Back") && (PWMType != "Front")) begin : g_chk_type
        $error("pwm_demodulator: PWMType must be \"Back\" or \"Front\"");
    end

    logic             w_pwm_s;
    logic             w_synch_s;
    logic             w_start;
    logic             w_rise;

    logic             r_synch_d;
    logic             r_pwm_d;
    logic [ACC_W-1:0] r_acc;
    logic [Size-1:0]  r_cnt;
    logic [1:0]       r_edges;
    logic [GAP_W-1:0] r_gap;
    pwm_dem_state_t   r_state;
    logic [Size-1:0]  r_code;
    logic             r_valid;
    logic             r_lost;
    logic             r_error;

    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W-1:0] w_acc_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic [Size-1:0]  w_cnt_base;
    logic [Size-1:0]  w_cnt_next;
    logic [1:0]       w_edges_base;
    logic [1:0]       w_edges_next;
    logic [GAP_W-1:0] w_gap_next;
    pwm_dem_state_t   w_state_next;
    logic [Size-1:0]  w_code_next;
    logic             w_valid_next;
    logic             w_lost_next;
    logic             w_error_next;

    sync2 u_sync_pwm (
        .clk   (Clock),
        .rst_n (Reset),
        .i_d   (PWM),
        .o_q   (w_pwm_s)
    );

    sync2 u_sync_synch (
        .clk   (Clock),
        .rst_n (Reset),
        .i_d   (Synch),
        .o_q   (w_synch_s)
    );

    assign w_start = w_synch_s & ~r_synch_d;
    assign w_rise  = w_pwm_s & ~r_pwm_d;

    // Bresenham duty accumulator; a start cycle reseeds first so its own
    // high tick is credited to the new period.
    always_comb begin
        w_acc_base = w_start ? ACC_W'(TICKS / 2) : r_acc;
        w_cnt_base = w_start ? '0 : r_cnt;
        w_acc_sum  = w_acc_base + ACC_W'(M);
        w_acc_next = w_acc_base;
        w_cnt_next = w_cnt_base;
        if (w_pwm_s) begin
            if (w_acc_sum >= ACC_W'(TICKS)) begin
                w_acc_next = w_acc_sum - ACC_W'(TICKS);
                if (w_cnt_base != Size'(M)) begin
                    w_cnt_next = w_cnt_base + Size'(1);
                end
            end else begin
                w_acc_next = w_acc_sum;
            end
        end
    end

    // Rising-edge and gap counters. r_pwm_d is not cleared at a period start,
    // so a pulse straddling the boundary (Front alignment at full duty, or a
    // Back pulse carried over) is never seen as a second edge.
    always_comb begin
        w_edges_base = w_start ? 2'd0 : r_edges;
        w_edges_next = w_edges_base;
        if (w_rise && (w_edges_base != 2'd2)) begin
            w_edges_next = w_edges_base + 2'd1;
        end
        if (w_start) begin
            w_gap_next = '0;
        end else if (r_gap == GAP_W'(GAP_MAX)) begin
            w_gap_next = r_gap;
        end else begin
            w_gap_next = r_gap + GAP_W'(1);
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        w_valid_next = 1'b0;
        w_lost_next  = r_lost;
        w_error_next = r_error;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (w_start) begin
                    w_code_next  = r_cnt;
                    w_error_next = (r_edges == 2'd2);
                    w_valid_next = 1'b1;
                end else if (w_gap_next == GAP_W'(GAP_MAX)) begin
                    w_state_next = LOST;
                    w_lost_next  = 1'b1;
                end
            end
            LOST: begin
                // Recovery period is discarded: no Valid here.
                if (w_start) begin
                    w_state_next = MEASURE;
                    w_lost_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_synch_d <= 1'b0;
            r_pwm_d   <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_edges   <= 2'd0;
            r_gap     <= '0;
            r_state   <= IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_lost    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_synch_d <= w_synch_s;
            r_pwm_d   <= w_pwm_s;
            r_acc     <= w_acc_next;
            r_cnt     <= w_cnt_next;
            r_edges   <= w_edges_next;
            r_gap     <= w_gap_next;
            r_state   <= w_state_next;
            r_code    <= w_code_next;
            r_valid   <= w_valid_next;
            r_lost    <= w_lost_next;
            r_error   <= w_error_next;
        end
    end

    assign Code  = r_code;
    assign Valid = r_valid;
    assign Lost  = r_lost;
    assign Error = r_error;

endmodule
